// File: rtl/pwm_channel_bank.sv
// Sixteen-channel PWM bank. All channels share one prescaler, one phase counter
// and one duty shadow, so every PWM-mode channel rises together at phase 0.
module pwm_channel_bank #(
    parameter int unsigned PRESCALE = 13
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] en_reg_out_7_0,
    input  logic [7:0] en_reg_out_15_8,
    input  logic [7:0] en_reg_pwm_7_0,
    input  logic [7:0] en_reg_pwm_15_8,
    input  logic [7:0] pwm_duty_cycle,
    output logic [15:0] out,
    output logic       period_start
);

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned PHASE_W = 8;
    localparam int unsigned N_CH    = 16;

    logic [CNT_W-1:0]   pre_cnt;
    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] shadow;
    logic               wrap_q;

    logic               tick_c;
    logic               wrap_c;
    logic               pwm_level_c;
    logic [N_CH-1:0]    en_out_c;
    logic [N_CH-1:0]    en_pwm_c;
    logic [N_CH-1:0]    out_next_c;

    // Step timing and period boundary detection.
    always_comb begin
        tick_c      = (pre_cnt == CNT_W'(PRESCALE - 1));
        wrap_c      = tick_c && (phase == {PHASE_W{1'b1}});
        pwm_level_c = (shadow == {PHASE_W{1'b1}}) || (phase < shadow);
    end

    // Per-channel level: disabled -> 0, static -> 1, PWM mode -> shared level.
    always_comb begin
        en_out_c   = {en_reg_out_15_8, en_reg_out_7_0};
        en_pwm_c   = {en_reg_pwm_15_8, en_reg_pwm_7_0};
        out_next_c = en_out_c & (~en_pwm_c | {N_CH{pwm_level_c}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            phase   <= '0;
            shadow  <= '0;
        end else begin
            pre_cnt <= tick_c ? '0 : pre_cnt + CNT_W'(1);
            if (tick_c) begin
                phase <= phase + PHASE_W'(1);
            end
            // Duty is only sampled at the wrap so a period is never cut short.
            if (wrap_c) begin
                shadow <= pwm_duty_cycle;
            end
        end
    end

    // wrap_q delays the pulse one cycle so it lines up with out showing phase 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_q       <= 1'b0;
            period_start <= 1'b0;
            out          <= '0;
        end else begin
            wrap_q       <= wrap_c;
            period_start <= wrap_q;
            out          <= out_next_c;
        end
    end

endmodule
